// File: rtl/gate_pkg.sv
// Shared definitions for the gate-level cell library: default sizes and the
// NAND helper reused by the individual gate cells.
package gate_pkg;

    localparam int DEFAULT_WIDTH = 1;
    localparam int DEFAULT_CNT_W = 8;

    // Widest operand the helper accepts; cells zero-extend narrower vectors
    // and keep only their own low bits of the result.
    localparam int NAND_FN_W = 64;

    function automatic logic [NAND_FN_W-1:0] nand_fn(
        input logic [NAND_FN_W-1:0] a,
        input logic [NAND_FN_W-1:0] b
    );
        return ~(a & b);
    endfunction

endpackage

// File: rtl/gate_reg_stage.sv
// Generic WIDTH-bit pipeline register with a synchronous active-high reset
// to a configurable value. Used to give gate cells a registered output.
module gate_reg_stage #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] data_q;

    // Next-state is simply the input: no enable, one cycle of latency.
    always_comb begin
        data_d = d;
    end

    // State register; reset wins over loading new data.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= RESET_VAL;
        end else begin
            data_q <= data_d;
        end
    end

    assign q = data_q;

endmodule

// File: rtl/nand_gate.sv
// Bitwise two-input NAND cell. The primary output is purely combinational;
// a registered copy and a saturating count of low-output cycles on bit 0
// are kept alongside it in the clk domain.
module nand_gate
    import gate_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i1,
    input  logic [WIDTH-1:0] i2,
    output logic [WIDTH-1:0] o,
    output logic [WIDTH-1:0] o_q,
    output logic [CNT_W-1:0] low_cnt
);

    logic [NAND_FN_W-1:0] a_ext;
    logic [NAND_FN_W-1:0] b_ext;
    logic [NAND_FN_W-1:0] nand_ext;
    logic                 unused_nand_bits;

    logic [CNT_W-1:0] low_cnt_d;
    logic [CNT_W-1:0] low_cnt_q;

    // Widen the operands to the helper's width; the extra high bits are
    // discarded, so their NAND value (all ones) never reaches the output.
    always_comb begin
        a_ext             = '0;
        b_ext             = '0;
        a_ext[WIDTH-1:0]  = i1;
        b_ext[WIDTH-1:0]  = i2;
        nand_ext          = nand_fn(a_ext, b_ext);
    end

    assign o                = nand_ext[WIDTH-1:0];
    assign unused_nand_bits = ^nand_ext;

    // Registered copy of o; idles at all ones, the NAND of zero inputs.
    gate_reg_stage #(
        .WIDTH     (WIDTH),
        .RESET_VAL ({WIDTH{1'b1}})
    ) u_o_reg (
        .clk (clk),
        .rst (rst),
        .d   (o),
        .q   (o_q)
    );

    // Count cycles where bit 0 of o is low, stopping at all ones.
    always_comb begin
        low_cnt_d = low_cnt_q;
        if ((o[0] == 1'b0) && (low_cnt_q != {CNT_W{1'b1}})) begin
            low_cnt_d = low_cnt_q + CNT_W'(1);
        end
    end

    // Counter register; reset takes priority over a counting cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            low_cnt_q <= '0;
        end else begin
            low_cnt_q <= low_cnt_d;
        end
    end

    assign low_cnt = low_cnt_q;

endmodule

// File: tb/tb_nand_gate.sv
// Self-checking bench for nand_gate: a WIDTH=1 cell, a WIDTH=1 cell with a
// 3-bit counter for saturation, and a WIDTH=4 cell.
module tb_nand_gate;

    logic       clk;
    logic       clk_run;
    logic       rst;
    logic       i1_n, i2_n;
    logic       o_n, o_q_n;
    logic [7:0] low_cnt_n;
    logic       o_s, o_q_s;
    logic [2:0] low_cnt_s;
    logic [3:0] i1_w, i2_w, o_w, o_q_w;
    logic [7:0] low_cnt_w;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic       oq;
        logic [7:0] cnt;
        logic [2:0] cnt3;
    } exp_t;

    exp_t sb[$];

    // Reference state for the next expected outputs of the 1-bit cells.
    logic       m_oq;
    logic [7:0] m_cnt;
    logic [2:0] m_cnt3;

    nand_gate #(.WIDTH(1), .CNT_W(8)) dut_n (
        .clk(clk), .rst(rst), .i1(i1_n), .i2(i2_n),
        .o(o_n), .o_q(o_q_n), .low_cnt(low_cnt_n)
    );

    nand_gate #(.WIDTH(1), .CNT_W(3)) dut_s (
        .clk(clk), .rst(rst), .i1(i1_n), .i2(i2_n),
        .o(o_s), .o_q(o_q_s), .low_cnt(low_cnt_s)
    );

    nand_gate #(.WIDTH(4), .CNT_W(8)) dut_w (
        .clk(clk), .rst(rst), .i1(i1_w), .i2(i2_w),
        .o(o_w), .o_q(o_q_w), .low_cnt(low_cnt_w)
    );

    initial clk = 1'b0;
    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    // Hard bound on total run time.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached (got running, need finished)");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic nand_truth(input logic a, input logic b);
        case ({a, b})
            2'b00:   return 1'b1;
            2'b01:   return 1'b1;
            2'b10:   return 1'b1;
            2'b11:   return 1'b0;
            default: return 1'bx;
        endcase
    endfunction

    // One clocked cycle on the 1-bit cells: check o immediately, check o_q
    // has not yet moved, queue the post-edge expectation and compare it.
    task automatic drive_cycle(input logic a, input logic b, input logic r);
        logic exp_o;
        exp_t e, got;
        i1_n = a;
        i2_n = b;
        rst  = r;
        exp_o = nand_truth(a, b);
        #1;
        vectors++;
        if (o_n !== exp_o) begin
            miscompares++;
            $display("[TB] FAIL comb_o: got %b need %b (a=%b b=%b)", o_n, exp_o, a, b);
        end
        vectors++;
        if (o_q_n !== m_oq) begin
            miscompares++;
            $display("[TB] FAIL oq_before_edge: got %b need %b", o_q_n, m_oq);
        end
        if (r) begin
            m_oq   = 1'b1;
            m_cnt  = 8'd0;
            m_cnt3 = 3'd0;
        end else begin
            m_oq = exp_o;
            if (exp_o == 1'b0) begin
                if (m_cnt  != 8'd255) m_cnt  = m_cnt + 8'd1;
                if (m_cnt3 != 3'd7)   m_cnt3 = m_cnt3 + 3'd1;
            end
        end
        e.oq = m_oq; e.cnt = m_cnt; e.cnt3 = m_cnt3;
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        vectors++;
        if (o_q_n !== got.oq) begin
            miscompares++;
            $display("[TB] FAIL o_q: got %b need %b", o_q_n, got.oq);
        end
        vectors++;
        if (low_cnt_n !== got.cnt) begin
            miscompares++;
            $display("[TB] FAIL low_cnt: got %0d need %0d", low_cnt_n, got.cnt);
        end
        vectors++;
        if (low_cnt_s !== got.cnt3) begin
            miscompares++;
            $display("[TB] FAIL low_cnt_sat: got %0d need %0d", low_cnt_s, got.cnt3);
        end
    endtask

    task automatic test_truth_table();
        logic [1:0] pat;
        for (int k = 0; k < 4; k++) begin
            pat  = 2'(k);
            i1_n = pat[1];
            i2_n = pat[0];
            #10;
            vectors++;
            if (o_n !== nand_truth(pat[1], pat[0])) begin
                miscompares++;
                $display("[TB] FAIL truth_%b: got %b need %b", pat, o_n, nand_truth(pat[1], pat[0]));
            end
        end
    endtask

    task automatic test_reset();
        drive_cycle(1'b0, 1'b0, 1'b1);
        drive_cycle(1'b0, 1'b0, 1'b1);
        vectors++;
        if (o_q_w !== 4'b1111) begin
            miscompares++;
            $display("[TB] FAIL reset_oq_wide: got %b need 1111", o_q_w);
        end
    endtask

    task automatic test_latency();
        drive_cycle(1'b1, 1'b1, 1'b0);
        drive_cycle(1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_comb_timing();
        #2;
        i1_n = 1'b1;
        i2_n = 1'b1;
        #1;
        vectors++;
        if (o_n !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL mid_cycle_o: got %b need 0", o_n);
        end
        i2_n = 1'b0;
        #1;
        vectors++;
        if (o_n !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL mid_cycle_o2: got %b need 1", o_n);
        end
    endtask

    task automatic test_counter();
        drive_cycle(1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 5; k++) drive_cycle(1'b1, 1'b1, 1'b0);
        vectors++;
        if (low_cnt_n !== 8'd5) begin
            miscompares++;
            $display("[TB] FAIL count_five: got %0d need 5", low_cnt_n);
        end
        for (int k = 0; k < 3; k++) drive_cycle(1'b0, 1'b0, 1'b0);
        vectors++;
        if (low_cnt_n !== 8'd5) begin
            miscompares++;
            $display("[TB] FAIL count_hold: got %0d need 5", low_cnt_n);
        end
    endtask

    task automatic test_saturation();
        drive_cycle(1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 10; k++) drive_cycle(1'b1, 1'b1, 1'b0);
        vectors++;
        if (low_cnt_s !== 3'd7) begin
            miscompares++;
            $display("[TB] FAIL saturate: got %0d need 7", low_cnt_s);
        end
    endtask

    task automatic test_mid_reset();
        drive_cycle(1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 5; k++) drive_cycle(1'b1, 1'b1, 1'b0);
        drive_cycle(1'b1, 1'b1, 1'b1);
        vectors++;
        if (low_cnt_n !== 8'd0 || o_q_n !== 1'b1 || o_n !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL mid_reset: got cnt=%0d oq=%b o=%b need cnt=0 oq=1 o=0",
                     low_cnt_n, o_q_n, o_n);
        end
        drive_cycle(1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_wide();
        i1_w = 4'b1100;
        i2_w = 4'b1010;
        #1;
        vectors++;
        if (o_w !== 4'b0111) begin
            miscompares++;
            $display("[TB] FAIL wide_o: got %b need 0111", o_w);
        end
        drive_cycle(1'b0, 1'b0, 1'b0);
        drive_cycle(1'b0, 1'b0, 1'b0);
        vectors++;
        if (o_q_w !== 4'b0111 || low_cnt_w !== 8'd0) begin
            miscompares++;
            $display("[TB] FAIL wide_hold: got oq=%b cnt=%0d need oq=0111 cnt=0", o_q_w, low_cnt_w);
        end
        i1_w = 4'b1111;
        i2_w = 4'b0001;
        #1;
        vectors++;
        if (o_w !== 4'b1110) begin
            miscompares++;
            $display("[TB] FAIL wide_o2: got %b need 1110", o_w);
        end
        for (int k = 0; k < 3; k++) drive_cycle(1'b0, 1'b0, 1'b0);
        vectors++;
        if (o_q_w !== 4'b1110 || low_cnt_w !== 8'd3) begin
            miscompares++;
            $display("[TB] FAIL wide_count: got oq=%b cnt=%0d need oq=1110 cnt=3", o_q_w, low_cnt_w);
        end
        i1_w = 4'b0000;
        i2_w = 4'b0000;
    endtask

    task automatic test_back_to_back();
        logic a, b, r;
        for (int k = 0; k < 40; k++) begin
            a = 1'($urandom_range(0, 1));
            b = 1'($urandom_range(0, 1));
            r = ($urandom_range(0, 7) == 0);
            drive_cycle(a, b, r);
        end
    endtask

    initial begin
        clk_run = 1'b0;
        rst     = 1'b1;
        i1_n    = 1'b0;
        i2_n    = 1'b0;
        i1_w    = 4'b0000;
        i2_w    = 4'b0000;
        m_oq    = 1'b1;
        m_cnt   = 8'd0;
        m_cnt3  = 3'd0;

        test_truth_table();

        clk_run = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_latency();
        test_comb_timing();
        test_counter();
        test_saturation();
        test_mid_reset();
        test_wide();
        test_back_to_back();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
